mini68k_prefetch: RTL and testbench

//   Instruction prefetch queue feeding the 16-bit IR to mini68k_decoder.

---
 rtl/mini68k_prefetch.sv | 159 +++++++++++++++
 tb/tb_mini68k_prefetch.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mini68k_prefetch.sv
`default_nettype none
// ============================================================================
// mini68k_prefetch
//   Sequential opcode prefetch queue with req/ack fetch bus and flush
//   redirect. Optional stat_fetch counter: MINI68K_PREFETCH_STATS_EN.
// Revision: 1.0
// ============================================================================
module mini68k_prefetch #(
    parameter int                ADDR_W   = 24,
    parameter int                DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              bus_req,
    output logic [ADDR_W-1:0] bus_addr,
    input  logic              bus_ack,
    input  logic [15:0]       bus_rdata,
    output logic [15:0]       ir,
    output logic [ADDR_W-1:0] ir_pc,
    output logic              ir_valid,
    input  logic              ir_ready,
    input  logic              flush,
`ifdef MINI68K_PREFETCH_STATS_EN
    input  logic [ADDR_W-1:0] flush_pc,
    output logic [31:0]       stat_fetch
`else
    input  logic [ADDR_W-1:0] flush_pc
`endif
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    localparam int                 c_PTR_W   = $clog2(DEPTH);
    localparam int                 c_CNT_W   = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH   = c_CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0]  c_PC_MASK = ~ADDR_W'(1);

    state_t              r_state, w_state_next;
    logic [ADDR_W-1:0]   r_fpc, w_fpc_next, r_old_addr;
    logic [15:0]         r_mem_word [DEPTH];
    logic [ADDR_W-1:0]   r_mem_pc   [DEPTH];
    logic [c_PTR_W-1:0]  r_rd, r_wr, w_rd_next;
    logic [c_CNT_W-1:0]  r_cnt, w_cnt_left, w_cnt_next;
    logic [15:0]         r_ir;
    logic [ADDR_W-1:0]   r_ir_pc;
    logic                w_push, w_pop;

    // Flush overrides both queue ports for the cycle it is asserted.
    assign w_push     = bus_ack && (r_state == S_REQ) && !flush;
    assign w_pop      = (r_cnt != '0) && ir_ready && !flush;
    assign w_rd_next  = r_rd + c_PTR_W'(w_pop);
    assign w_cnt_left = r_cnt - c_CNT_W'(w_pop);
    assign w_cnt_next = w_cnt_left + c_CNT_W'(w_push);

    always_comb begin
        w_state_next = r_state;
        w_fpc_next   = r_fpc;
        if (flush) begin
            w_fpc_next = flush_pc & c_PC_MASK;
        end else if (w_push) begin
            w_fpc_next = r_fpc + ADDR_W'(2);
        end
        case (r_state)
            S_IDLE: begin
                if (flush || (w_cnt_next < c_DEPTH)) begin
                    w_state_next = S_REQ;
                end
            end
            S_REQ: begin
                if (bus_ack) begin
                    w_state_next = (flush || (w_cnt_next < c_DEPTH)) ? S_REQ : S_IDLE;
                end else if (flush) begin
                    w_state_next = S_DISCARD;
                end
            end
            S_DISCARD: begin
                if (bus_ack) begin
                    w_state_next = S_REQ;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_fpc      <= RESET_PC & c_PC_MASK;
            r_old_addr <= RESET_PC & c_PC_MASK;
            r_rd       <= '0;
            r_wr       <= '0;
            r_cnt      <= '0;
            r_ir       <= '0;
            r_ir_pc    <= '0;
        end else begin
            r_state <= w_state_next;
            r_fpc   <= w_fpc_next;
            // Remembers the in-flight address so DISCARD can keep it on the bus.
            if (r_state == S_REQ) begin
                r_old_addr <= r_fpc;
            end
            if (flush) begin
                r_rd  <= '0;
                r_wr  <= '0;
                r_cnt <= '0;
            end else begin
                r_cnt <= w_cnt_next;
                r_rd  <= w_rd_next;
                if (w_push) begin
                    r_wr <= r_wr + c_PTR_W'(1);
                end
                // Head register tracks the next head; left untouched when empty.
                if (w_cnt_next != '0) begin
                    if (w_cnt_left == '0) begin
                        r_ir    <= bus_rdata;
                        r_ir_pc <= r_fpc;
                    end else begin
                        r_ir    <= r_mem_word[w_rd_next];
                        r_ir_pc <= r_mem_pc[w_rd_next];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_word[r_wr] <= bus_rdata;
            r_mem_pc[r_wr]   <= r_fpc;
        end
    end

    assign bus_req  = (r_state != S_IDLE);
    assign bus_addr = (r_state == S_DISCARD) ? r_old_addr : r_fpc;
    assign ir       = r_ir;
    assign ir_pc    = r_ir_pc;
    assign ir_valid = (r_cnt != '0);

`ifdef MINI68K_PREFETCH_STATS_EN
    logic [31:0] r_stat;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat <= '0;
        end else if (bus_ack && (r_state != S_IDLE)) begin
            r_stat <= r_stat + 32'd1;
        end
    end

    assign stat_fetch = r_stat;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mini68k_prefetch.sv
`default_nettype none
// Testbench for mini68k_prefetch: scoreboard of expected {word, pc} entries
// pushed on accepted fetches and popped on ir handshakes.
module tb_mini68k_prefetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bus_req;
    logic [23:0] bus_addr;
    logic        bus_ack = 1'b0;
    logic [15:0] bus_rdata = '0;
    logic [15:0] ir;
    logic [23:0] ir_pc;
    logic        ir_valid;
    logic        ir_ready = 1'b0;
    logic        flush = 1'b0;
    logic [23:0] flush_pc = '0;
`ifdef MINI68K_PREFETCH_STATS_EN
    logic [31:0] stat_fetch;
`endif

    mini68k_prefetch #(.ADDR_W(24), .DEPTH(2), .RESET_PC(24'h000000)) dut (
        .clk(clk), .rst(rst),
        .bus_req(bus_req), .bus_addr(bus_addr), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .ir_ready(ir_ready),
        .flush(flush),
`ifdef MINI68K_PREFETCH_STATS_EN
        .flush_pc(flush_pc), .stat_fetch(stat_fetch)
`else
        .flush_pc(flush_pc)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] w;
        logic [23:0] pc;
    } ent_t;

    ent_t        sb[$];
    logic [23:0] exp_pc;
    int          total = 0;
    int          bad   = 0;
    int          n_ack = 0;

    function automatic logic [15:0] memw(input logic [23:0] a);
        return a[16:1] ^ 16'hC35A;
    endfunction

    // One bus cycle: inputs set at negedge, outputs sampled there too.
    task automatic drive(input bit ack_en, input bit rdy, input bit fl, input logic [23:0] fpc,
                         input bit keep, output bit acked, output bit popped,
                         output logic [15:0] pw, output logic [23:0] ppc, output logic [23:0] aaddr);
        ent_t e;
        @(negedge clk);
        acked    = bus_req && ack_en;
        aaddr    = bus_addr;
        popped   = ir_valid && rdy;
        pw       = ir;
        ppc      = ir_pc;
        bus_ack  = acked;
        bus_rdata = memw(bus_addr);
        ir_ready = rdy;
        flush    = fl;
        flush_pc = fpc;
        if (acked) begin
            n_ack++;
            if (keep && !fl) begin
                e.w  = memw(exp_pc);
                e.pc = exp_pc;
                sb.push_back(e);
                exp_pc = exp_pc + 24'd2;
            end
        end
        @(posedge clk);
        #1;
        bus_ack = 1'b0;
        flush   = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; bus_ack = 1'b0; flush = 1'b0; ir_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (bus_req !== 1'b0) begin bad++; $display("FAIL reset_bus_req got=%b want=0", bus_req); end
        total++; if (bus_addr !== 24'h0) begin bad++; $display("FAIL reset_bus_addr got=%h want=000000", bus_addr); end
        total++; if (ir_valid !== 1'b0) begin bad++; $display("FAIL reset_ir_valid got=%b want=0", ir_valid); end
        total++; if ({ir, ir_pc} !== 40'h0) begin bad++; $display("FAIL reset_ir got=%h/%h want=0/0", ir, ir_pc); end
`ifdef MINI68K_PREFETCH_STATS_EN
        total++; if (stat_fetch !== 32'd0) begin bad++; $display("FAIL reset_stat got=%0d want=0", stat_fetch); end
`endif
        rst = 1'b0;
        @(posedge clk);
        #1;
        total++; if (bus_req !== 1'b1 || bus_addr !== 24'h0) begin
            bad++; $display("FAIL first_req got req=%b addr=%h want req=1 addr=000000", bus_req, bus_addr);
        end
        sb.delete();
        exp_pc = 24'h0;
        n_ack  = 0;
    endtask

    task automatic drain(input string name);
        bit a, p; logic [15:0] w; logic [23:0] pc, ad; ent_t e;
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 1'b0, 24'h0, 1'b1, a, p, w, pc, ad);
            if (p) begin
                total++;
                if (sb.size() == 0) begin bad++; $display("FAIL %s_extra got=%h/%h want=none", name, w, pc); end
                else begin
                    e = sb.pop_front();
                    if ({w, pc} !== {e.w, e.pc}) begin bad++; $display("FAIL %s_drain got=%h/%h want=%h/%h", name, w, pc, e.w, e.pc); end
                end
            end
        end
        total++; if (sb.size() != 0) begin bad++; $display("FAIL %s_lost got=%0d left want=0", name, sb.size()); end
    endtask

    task automatic test_stream();
        bit a, p; logic [15:0] w; logic [23:0] pc, ad; ent_t e; int k = 0;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b1, 1'b0, 24'h0, 1'b1, a, p, w, pc, ad);
            if (i == 1) begin
                total++; if (p !== 1'b1) begin bad++; $display("FAIL stream_latency got ir_valid=%b want=1", p); end
            end
            if (p) begin
                total++;
                if (sb.size() == 0) begin bad++; $display("FAIL stream_extra got=%h/%h want=none", w, pc); end
                else begin
                    e = sb.pop_front();
                    if ({w, pc} !== {e.w, e.pc} || (k < 4 && pc !== 24'(2 * k))) begin
                        bad++; $display("FAIL stream_word got=%h/%h want=%h/%h", w, pc, e.w, e.pc);
                    end
                end
                k++;
            end
        end
        drain("stream");
    endtask

    task automatic test_full();
        bit a, p; logic [15:0] w, lw; logic [23:0] pc, ad, lpc; ent_t e; int na = 0, np = 0;
        lw = '0; lpc = '0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 1'b0, 24'h0, 1'b1, a, p, w, pc, ad);
            if (a) na++;
        end
        total++; if (na != 2) begin bad++; $display("FAIL full_acks got=%0d want=2", na); end
        total++; if (bus_req !== 1'b0) begin bad++; $display("FAIL full_req got=%b want=0", bus_req); end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 1'b0, 24'h0, 1'b1, a, p, w, pc, ad);
            if (p) begin
                np++; lw = w; lpc = pc;
                total++;
                if (sb.size() == 0) begin bad++; $display("FAIL full_extra got=%h/%h want=none", w, pc); end
                else begin
                    e = sb.pop_front();
                    if ({w, pc} !== {e.w, e.pc}) begin bad++; $display("FAIL full_order got=%h/%h want=%h/%h", w, pc, e.w, e.pc); end
                end
            end
        end
        total++; if (np != 2) begin bad++; $display("FAIL full_pops got=%0d want=2", np); end
        total++; if (ir_valid !== 1'b0 || {ir, ir_pc} !== {lw, lpc}) begin
            bad++; $display("FAIL empty_hold got=%b %h/%h want=0 %h/%h", ir_valid, ir, ir_pc, lw, lpc);
        end
        total++; if (sb.size() != 0) begin bad++; $display("FAIL full_lost got=%0d want=0", sb.size()); end
    endtask

    task automatic test_flush_pending();
        bit a, p; logic [15:0] w; logic [23:0] pc, ad, old; ent_t e; int kept = 0; int k = 0;
        drive(1'b1, 1'b0, 1'b0, 24'h0, 1'b1, a, p, w, pc, ad);
        old = exp_pc;
        drive(1'b0, 1'b0, 1'b1, 24'h001001, 1'b0, a, p, w, pc, ad);
        sb.delete();
        exp_pc = 24'h001000;
        total++; if (ir_valid !== 1'b0 || bus_req !== 1'b1 || bus_addr !== old) begin
            bad++; $display("FAIL discard_hold got v=%b req=%b addr=%h want v=0 req=1 addr=%h", ir_valid, bus_req, bus_addr, old);
        end
        drive(1'b0, 1'b1, 1'b0, 24'h0, 1'b0, a, p, w, pc, ad);
        drive(1'b1, 1'b1, 1'b0, 24'h0, 1'b0, a, p, w, pc, ad);
        total++; if (a !== 1'b1 || ad !== old) begin
            bad++; $display("FAIL discard_ack got ack=%b addr=%h want ack=1 addr=%h", a, ad, old);
        end
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b1, 1'b0, 24'h0, 1'b1, a, p, w, pc, ad);
            if (a && kept++ == 0) begin
                total++; if (ad !== 24'h001000) begin bad++; $display("FAIL redirect_addr got=%h want=001000", ad); end
            end
            if (p) begin
                total++;
                if (sb.size() == 0) begin bad++; $display("FAIL flushp_extra got=%h/%h want=none", w, pc); end
                else begin
                    e = sb.pop_front();
                    if ({w, pc} !== {e.w, e.pc} || (k == 0 && pc !== 24'h001000)) begin
                        bad++; $display("FAIL flushp_word got=%h/%h want=%h/%h", w, pc, e.w, e.pc);
                    end
                end
                k++;
            end
        end
        drain("flushp");
    endtask

    task automatic test_flush_ack();
        bit a, p; logic [15:0] w; logic [23:0] pc, ad; ent_t e; int k = 0;
        drive(1'b1, 1'b0, 1'b0, 24'h0, 1'b1, a, p, w, pc, ad);
        drive(1'b1, 1'b1, 1'b1, 24'h002000, 1'b0, a, p, w, pc, ad);
        sb.delete();
        exp_pc = 24'h002000;
        total++; if (a !== 1'b1) begin bad++; $display("FAIL flusha_ack got=%b want=1", a); end
        total++; if (ir_valid !== 1'b0 || bus_req !== 1'b1 || bus_addr !== 24'h002000) begin
            bad++; $display("FAIL flusha_next got v=%b req=%b addr=%h want v=0 req=1 addr=002000", ir_valid, bus_req, bus_addr);
        end
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b1, 1'b0, 24'h0, 1'b1, a, p, w, pc, ad);
            if (p) begin
                total++;
                if (sb.size() == 0) begin bad++; $display("FAIL flusha_extra got=%h/%h want=none", w, pc); end
                else begin
                    e = sb.pop_front();
                    if ({w, pc} !== {e.w, e.pc} || (k == 0 && pc !== 24'h002000)) begin
                        bad++; $display("FAIL flusha_word got=%h/%h want=%h/%h", w, pc, e.w, e.pc);
                    end
                end
                k++;
            end
        end
        drain("flusha");
    endtask

    task automatic test_wrap();
        bit a, p; logic [15:0] w; logic [23:0] pc, ad; ent_t e; int kept = 0;
        drive(1'b1, 1'b1, 1'b1, 24'hFFFFFD, 1'b0, a, p, w, pc, ad);
        sb.delete();
        exp_pc = 24'hFFFFFC;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 1'b0, 24'h0, 1'b1, a, p, w, pc, ad);
            if (a) begin
                if (kept == 2) begin
                    total++; if (ad !== 24'h000000) begin bad++; $display("FAIL wrap_addr got=%h want=000000", ad); end
                end
                kept++;
            end
            if (p) begin
                total++;
                if (sb.size() == 0) begin bad++; $display("FAIL wrap_extra got=%h/%h want=none", w, pc); end
                else begin
                    e = sb.pop_front();
                    if ({w, pc} !== {e.w, e.pc}) begin bad++; $display("FAIL wrap_word got=%h/%h want=%h/%h", w, pc, e.w, e.pc); end
                end
            end
        end
        drain("wrap");
    endtask

`ifdef MINI68K_PREFETCH_STATS_EN
    task automatic test_stats();
        bit a, p; logic [15:0] w; logic [23:0] pc, ad;
        test_reset();
        drive(1'b1, 1'b0, 1'b0, 24'h0, 1'b1, a, p, w, pc, ad);
        drive(1'b1, 1'b0, 1'b0, 24'h0, 1'b1, a, p, w, pc, ad);
        drive(1'b0, 1'b0, 1'b1, 24'h000300, 1'b0, a, p, w, pc, ad);
        drive(1'b0, 1'b0, 1'b1, 24'h000400, 1'b0, a, p, w, pc, ad);
        drive(1'b1, 1'b0, 1'b0, 24'h0, 1'b0, a, p, w, pc, ad);
        sb.delete();
        exp_pc = 24'h000400;
        drive(1'b1, 1'b1, 1'b0, 24'h0, 1'b1, a, p, w, pc, ad);
        drive(1'b1, 1'b1, 1'b0, 24'h0, 1'b1, a, p, w, pc, ad);
        drive(1'b0, 1'b1, 1'b0, 24'h0, 1'b1, a, p, w, pc, ad);
        total++; if (stat_fetch !== 32'd5 || n_ack != 5) begin
            bad++; $display("FAIL stat_count got=%0d acks=%0d want=5", stat_fetch, n_ack);
        end
        test_reset();
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stream();
        test_full();
        test_flush_pending();
        test_flush_ack();
        test_wrap();
        test_reset();
`ifdef MINI68K_PREFETCH_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
